output_controller: RTL and testbench



---
 rtl/output_controller.sv | 195 +++++++++++++++++++
 tb/tb_output_controller.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/output_controller.sv
// output_controller: transmit side of the board UART.
// Output requests from the core are queued in an on-chip FIFO (one entry per
// request, carrying either one byte or a little-endian 32-bit word) and are
// serialized onto txd as 8N1 frames, CLK_PER_BIT clocks per bit.
// Optional feature macro: OUTPUT_BYTE_COUNT_EN enables the bytes_sent counter;
// without it bytes_sent is tied to zero.
module output_controller #(
  parameter int CLK_PER_BIT = 868,
  parameter int DEPTH       = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        write_output,
  input  logic        output_word,
  input  logic [31:0] output_wdata,
  output logic        stall,
  output logic        txd,
  output logic        tx_idle,
  output logic [31:0] bytes_sent
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int TW = (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT) : 1;
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [TW-1:0] LAST_TCK = TW'(CLK_PER_BIT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  // FIFO storage: {word flag, payload}
  logic [32:0]   mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW:0]   count;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;

  // Serializer state
  state_t        state, state_n;
  logic [TW-1:0] timer, timer_n;
  logic [2:0]    bit_idx, bit_n;
  logic [1:0]    byte_idx, byte_n;
  logic          cur_word, cur_word_n;
  logic [31:0]   cur_data, cur_data_n;
  logic          timer_last;
  logic          more_bytes;
  logic          txd_n;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  // Stall looks only at the registered occupancy, so a pop happening in the
  // same cycle does not let the write through.
  assign stall   = write_output & full;
  assign push    = write_output & ~full;
  assign tx_idle = empty & (state == S_IDLE);

  // FIFO write port; payload storage needs no reset
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wptr] <= {output_word, output_wdata};
    end
  end

  // FIFO pointers and occupancy; simultaneous push and pop leave count alone
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  assign timer_last = (timer == LAST_TCK);
  // A word entry carries four bytes, a byte entry just one.
  assign more_bytes = cur_word & (byte_idx != 2'd3);

  // Serializer next-state logic; txd is derived from the next state so the
  // registered pin lines up with the state it belongs to.
  always_comb begin
    state_n    = state;
    timer_n    = timer + TW'(1);
    bit_n      = bit_idx;
    byte_n     = byte_idx;
    cur_word_n = cur_word;
    cur_data_n = cur_data;
    pop        = 1'b0;
    txd_n      = 1'b1;

    case (state)
      S_IDLE: begin
        timer_n = '0;
        if (!empty) begin
          pop                     = 1'b1;
          {cur_word_n, cur_data_n} = mem[rptr];
          byte_n                  = 2'd0;
          bit_n                   = 3'd0;
          state_n                 = S_START;
        end
      end
      S_START: begin
        if (timer_last) begin
          timer_n = '0;
          bit_n   = 3'd0;
          state_n = S_DATA;
        end
      end
      S_DATA: begin
        if (timer_last) begin
          timer_n = '0;
          if (bit_idx == 3'd7) begin
            state_n = S_STOP;
          end else begin
            bit_n = bit_idx + 3'd1;
          end
        end
      end
      S_STOP: begin
        if (timer_last) begin
          timer_n = '0;
          if (more_bytes) begin
            byte_n  = byte_idx + 2'd1;
            state_n = S_START;
          end else begin
            state_n = S_IDLE;
          end
        end
      end
      default: begin
        state_n = S_IDLE;
        timer_n = '0;
      end
    endcase

    case (state_n)
      S_START: txd_n = 1'b0;
      S_DATA:  txd_n = cur_data_n[{byte_n, bit_n}];
      default: txd_n = 1'b1;
    endcase
  end

  // Serializer control registers and the txd output flop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      timer    <= '0;
      bit_idx  <= 3'd0;
      byte_idx <= 2'd0;
      cur_word <= 1'b0;
      txd      <= 1'b1;
    end else begin
      state    <= state_n;
      timer    <= timer_n;
      bit_idx  <= bit_n;
      byte_idx <= byte_n;
      cur_word <= cur_word_n;
      txd      <= txd_n;
    end
  end

  // Shift payload of the entry being transmitted
  always_ff @(posedge clk) begin
    cur_data <= cur_data_n;
  end

`ifdef OUTPUT_BYTE_COUNT_EN
  logic byte_done;
  assign byte_done = (state == S_STOP) & timer_last;

  // Completed-frame counter, wraps naturally at 2^32
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bytes_sent <= '0;
    end else if (byte_done) begin
      bytes_sent <= bytes_sent + 32'd1;
    end
  end
`else
  assign bytes_sent = '0;
`endif

endmodule

// File: tb/tb_output_controller.sv
// Bench for output_controller with CLK_PER_BIT=4, DEPTH=4.
// A cycle-count model (FIFO as a queue, serializer as a busy-cycle budget)
// predicts stall/txd/tx_idle/bytes_sent every cycle, and an independent UART
// receiver decodes txd into bytes that are compared with what was written.
module tb_output_controller;
  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int FRAME = 10 * CPB;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        write_output = 1'b0;
  logic        output_word = 1'b0;
  logic [31:0] output_wdata = '0;
  logic        stall;
  logic        txd;
  logic        tx_idle;
  logic [31:0] bytes_sent;

  output_controller #(.CLK_PER_BIT(CPB), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .write_output(write_output), .output_word(output_word),
    .output_wdata(output_wdata), .stall(stall), .txd(txd), .tx_idle(tx_idle),
    .bytes_sent(bytes_sent)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct { logic word; logic [31:0] data; } ent_t;
  ent_t        mq[$];
  logic [7:0]  exp_q[$];
  int          ser_left = 0;
  int          cur_len  = 0;
  logic [31:0] cur_dat  = '0;
  logic [31:0] mbytes   = '0;
  logic        obs_txd, obs_idle, obs_stall;
  int          cyc = 0;

  logic [7:0]  rx_q[$];
  int          rx_ferr = 0;
  logic        rx_busy = 1'b0;
  int          rx_cnt  = 0;
  logic [7:0]  rx_sh   = '0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s (cycle %0d): got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  function automatic logic model_txd();
    int pos, b, slot;
    if (ser_left == 0) return 1'b1;
    pos  = cur_len - ser_left;
    b    = pos / FRAME;
    slot = (pos % FRAME) / CPB;
    if (slot == 0) return 1'b0;
    if (slot == 9) return 1'b1;
    return cur_dat[8*b + slot - 1];
  endfunction

  function automatic logic [31:0] model_bs();
`ifdef OUTPUT_BYTE_COUNT_EN
    return mbytes;
`else
    return 32'd0;
`endif
  endfunction

  task automatic model_clear();
    mq.delete();
    exp_q.delete();
    rx_q.delete();
    ser_left = 0;
    cur_len  = 0;
    mbytes   = '0;
    rx_ferr  = 0;
  endtask

  // One clock cycle: drive inputs, compare outputs with the model, advance.
  task automatic step(input logic wr, input logic wd, input logic [31:0] d, output logic acc);
    logic ex_stall;
    ent_t e;
    write_output = wr;
    output_word  = wd;
    output_wdata = d;
    #1;
    ex_stall  = wr && (mq.size() == DEPTH);
    obs_txd   = txd;
    obs_idle  = tx_idle;
    obs_stall = stall;
    check("cycle {stall,txd,tx_idle,bytes_sent}", {29'd0, stall, txd, tx_idle, bytes_sent},
          {29'd0, ex_stall, model_txd(), (mq.size() == 0 && ser_left == 0), model_bs()});
    acc = wr && (mq.size() != DEPTH);
    @(posedge clk);
    if (ser_left > 0) begin
      if ((cur_len - ser_left + 1) % FRAME == 0) mbytes = mbytes + 32'd1;
      ser_left--;
    end else if (mq.size() > 0) begin
      e        = mq.pop_front();
      cur_dat  = e.data;
      cur_len  = (e.word ? 4 : 1) * FRAME;
      ser_left = cur_len;
    end
    if (acc) begin
      e.word = wd;
      e.data = d;
      mq.push_back(e);
      for (int j = 0; j < (wd ? 4 : 1); j++) exp_q.push_back(d[8*j +: 8]);
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic idle_step();
    logic a;
    step(1'b0, 1'b0, 32'h0, a);
  endtask

  task automatic write_hold(input logic wd, input logic [31:0] d, output int stalls);
    logic a;
    stalls = 0;
    a = 1'b0;
    while (!a && stalls < 1000) begin
      step(1'b1, wd, d, a);
      if (!a) stalls++;
    end
    if (!a) check("write_hold timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_idle(input int maxc);
    int n;
    n = 0;
    do begin
      idle_step();
      n++;
    end while (!obs_idle && n < maxc);
    if (!obs_idle) check("wait_idle timeout", 64'd0, 64'd1);
  endtask

  task automatic compare_rx(input string nm);
    int n;
    check({nm, " byte count"}, 64'(rx_q.size()), 64'(exp_q.size()));
    n = (rx_q.size() < exp_q.size()) ? rx_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check({nm, " byte"}, 64'(rx_q[i]), 64'(exp_q[i]));
    check({nm, " framing errors"}, 64'(rx_ferr), 64'd0);
    rx_q.delete();
    exp_q.delete();
    rx_ferr = 0;
  endtask

  // Independent UART receiver: start detected on a low sample, mid-bit sampling
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        rx_busy = 1'b0;
      end else if (!rx_busy) begin
        if (txd === 1'b0) begin
          rx_busy = 1'b1;
          rx_cnt  = 0;
        end
      end else begin
        rx_cnt++;
        if (rx_cnt < 9*CPB && (rx_cnt % CPB) == CPB/2) begin
          rx_sh[rx_cnt/CPB - 1] = txd;
        end else if (rx_cnt == 9*CPB + CPB/2) begin
          if (txd !== 1'b1) rx_ferr++;
          rx_q.push_back(rx_sh);
          rx_busy = 1'b0;
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1, "watchdog");
  end

  typedef struct { logic word; logic [31:0] data; int n; logic [31:0] seq; } vec_t;

  initial begin
    vec_t tbl[5];
    int   n, m, st;
    int   stl[6];
    int   stall_seen;
    logic a, wr;

    tbl[0] = '{1'b0, 32'h0000_0041, 1, 32'h4100_0000};
    tbl[1] = '{1'b1, 32'h4443_4241, 4, 32'h4142_4344};
    tbl[2] = '{1'b0, 32'hDEAD_BE80, 1, 32'h8000_0000};
    tbl[3] = '{1'b1, 32'h00FF_55AA, 4, 32'hAA55_FF00};
    tbl[4] = '{1'b1, 32'h8000_0001, 4, 32'h0100_0080};

    // reset values, with a write request held to show stall stays low
    rst = 1'b1;
    write_output = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("reset {stall,txd,tx_idle}", {61'd0, stall, txd, tx_idle}, {61'd0, 3'b011});
    check("reset bytes_sent", 64'(bytes_sent), 64'd0);
    write_output = 1'b0;
    model_clear();
    @(negedge clk);
    rst = 1'b0;

    // single byte 0x41: start-bit latency and frame length
    write_hold(1'b0, 32'h41, st);
    check("first write stall cycles", 64'(st), 64'd0);
    n = 0;
    do begin idle_step(); n++; end while (obs_txd !== 1'b0 && n < 20);
    check("accept to start bit", 64'(n), 64'd2);
    m = 0;
    do begin idle_step(); m++; end while (!obs_idle && m < 200);
    check("start bit to tx_idle", 64'(m), 64'(FRAME));
    compare_rx("byte 0x41");

    // table of single transactions with their expected byte order on the wire
    for (int i = 0; i < 5; i++) begin
      write_hold(tbl[i].word, tbl[i].data, st);
      wait_idle(400);
      check("table byte count", 64'(rx_q.size()), 64'(tbl[i].n));
      for (int j = 0; j < tbl[i].n && j < rx_q.size(); j++)
        check("table byte", 64'(rx_q[j]), 64'(tbl[i].seq[31-8*j -: 8]));
      rx_q.delete();
      exp_q.delete();
    end

    // fill: one frame in flight, then 6 back-to-back byte writes
    write_hold(1'b0, 32'h10, st);
    n = 0;
    do begin idle_step(); n++; end while (obs_txd !== 1'b0 && n < 20);
    for (int i = 0; i < 6; i++) write_hold(1'b0, 32'h20 + i, stl[i]);
    for (int i = 0; i < 4; i++) check("fill no stall", 64'(stl[i]), 64'd0);
    check("fill 5th stalled", 64'(stl[4] > 0), 64'd1);
    check("fill 6th stalled", 64'(stl[5] > 0), 64'd1);
    wait_idle(800);
    compare_rx("fill");

    // pointer wrap: 3*DEPTH byte writes
    for (int i = 0; i < 3*DEPTH; i++) write_hold(1'b0, $urandom, st);
    wait_idle(2000);
    compare_rx("wrap");

    // randomized traffic
    stall_seen = 0;
    for (int c = 0; c < 2500; c++) begin
      wr = ($urandom_range(0, 7) == 0);
      step(wr, 1'(($urandom_range(0, 1))), $urandom, a);
      if (obs_stall) stall_seen++;
    end
    wait_idle(2000);
    compare_rx("random");
    check("random stall exercised", 64'(stall_seen > 0), 64'd1);

    // reset during the 2nd byte of a word, with another entry still queued
    write_hold(1'b1, 32'h4443_4241, st);
    write_hold(1'b0, 32'h55, st);
    n = 0;
    do begin idle_step(); n++; end while (obs_txd !== 1'b0 && n < 20);
    repeat (FRAME + 2*CPB + 1) idle_step();
    #2 rst = 1'b1;
    #1;
    check("async reset txd", 64'(txd), 64'd1);
    check("async reset tx_idle", 64'(tx_idle), 64'd1);
    model_clear();
    @(negedge clk);
    @(negedge clk);
    model_clear();
    rst = 1'b0;
    repeat (200) idle_step();
    check("post reset tx_idle", 64'(obs_idle), 64'd1);
    check("post reset no frames", 64'(rx_q.size()), 64'd0);

    // byte counter: two words and one byte
    write_hold(1'b1, 32'h0403_0201, st);
    write_hold(1'b1, 32'h0807_0605, st);
    write_hold(1'b0, 32'h09, st);
    wait_idle(1000);
`ifdef OUTPUT_BYTE_COUNT_EN
    check("bytes_sent after 2 words + 1 byte", 64'(bytes_sent), 64'd9);
`else
    check("bytes_sent tied low", 64'(bytes_sent), 64'd0);
`endif
    compare_rx("counter traffic");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
